// File: rtl/lcd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module  : lcd_cmd_engine
// Brief   : Turns each LSU store to the LCD register into one HD44780 write.
//           Exposes busy/overrun status so firmware can poll for completion.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_cmd_engine #(
  parameter int SETUP_CYC   = 2,
  parameter int EN_HIGH_CYC = 12,
  parameter int HOLD_CYC    = 2,
  parameter int EXEC_CYC    = 2000,
  parameter int SLOW_CYC    = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_wdata,
  output logic [31:0] o_status,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  localparam int C_MAX_A   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int C_MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int C_MAX_C   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_MAX_CYC = (C_MAX_C > SLOW_CYC) ? C_MAX_C : SLOW_CYC;
  localparam int CW        = $clog2(C_MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          slow_q, slow_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          on_q, on_d;
  logic          ovr_q, ovr_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          cnt_last;
  logic          is_slow_cmd;

  assign cnt_last = (cnt_q == CW'(1));

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_slow_cmd = ~i_lcd_wdata[9] && (i_lcd_wdata[7:2] == 6'd0) &&
                       (i_lcd_wdata[1:0] != 2'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slow_d  = slow_q;
    rs_d    = rs_q;
    data_d  = data_q;
    on_d    = on_q;
    ovr_d   = ovr_q;

    if (i_lcd_wr) begin
      on_d = i_lcd_wdata[31];
      if (i_lcd_wdata[30]) ovr_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_lcd_wr) begin
          rs_d    = i_lcd_wdata[9];
          data_d  = i_lcd_wdata[7:0];
          slow_d  = is_slow_cmd;
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYC);
        end
      end
      S_SETUP: begin
        if (cnt_last) begin
          state_d = S_PULSE;
          cnt_d   = CW'(EN_HIGH_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_last) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_last) begin
          state_d = S_WAIT;
          cnt_d   = slow_q ? CW'(SLOW_CYC) : CW'(EXEC_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A dropped write sets overrun even when it also carries CLR_OVR.
    if (i_lcd_wr && (state_q != S_IDLE)) ovr_d = 1'b1;

    en_d   = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      slow_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'd0;
      on_q    <= 1'b0;
      ovr_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slow_q  <= slow_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      on_q    <= on_d;
      ovr_q   <= ovr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  logic w_unused;
  assign w_unused = ^{i_lcd_wdata[29:10], i_lcd_wdata[8]};

  assign o_status   = {on_q, 29'd0, ovr_q, busy_q};
  assign o_lcd_on   = on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_cmd_engine
// Brief   : Self-checking bench for lcd_cmd_engine: phase-based reference model,
//           directed boundary cases and randomized writes/resets.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_engine;

  localparam int P_SETUP = 2;
  localparam int P_HIGH  = 3;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 5;
  localparam int P_SLOW  = 9;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr    = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] o_status;
  logic        o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0]  o_lcd_data;

  always #5 clk = ~clk;

  lcd_cmd_engine #(
    .SETUP_CYC  (P_SETUP),
    .EN_HIGH_CYC(P_HIGH),
    .HOLD_CYC   (P_HOLD),
    .EXEC_CYC   (P_EXEC),
    .SLOW_CYC   (P_SLOW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_lcd_wr   (wr),
    .i_lcd_wdata(wdata),
    .o_status   (o_status),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a transaction is a count of elapsed cycles (phase) since
  // the accepting edge; busy and EN are just windows over that count.
  int         m_phase = 0;
  int         m_total = 0;
  bit         m_on    = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_rs    = 1'b0;
  logic [7:0] m_data  = 8'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_total = 0;
      m_on    = 1'b0;
      m_ovr   = 1'b0;
      m_rs    = 1'b0;
      m_data  = 8'd0;
    end else begin
      bit busy_now;
      busy_now = (m_phase != 0);
      if (busy_now) m_phase = (m_phase == m_total) ? 0 : m_phase + 1;
      if (wr) begin
        m_on = wdata[31];
        if (wdata[30]) m_ovr = 1'b0;
        if (busy_now) begin
          m_ovr = 1'b1;
        end else begin
          m_rs    = wdata[9];
          m_data  = wdata[7:0];
          m_total = P_SETUP + P_HIGH + P_HOLD +
                    ((!wdata[9] && wdata[7:0] >= 8'd1 && wdata[7:0] <= 8'd3) ? P_SLOW : P_EXEC);
          m_phase = 1;
        end
      end
    end
  end

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      bit m_en;
      m_en = (m_phase >= P_SETUP + 1) && (m_phase <= P_SETUP + P_HIGH);
      chk("status", o_status, {m_on, 29'd0, m_ovr, (m_phase != 0)});
      chk("bus", {20'd0, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data},
                 {20'd0, m_on, m_en, m_rs, 1'b0, m_data});
    end
  end

  task automatic tick(input bit w, input logic [31:0] d);
    wr    = w;
    wdata = d;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  // Counts busy cycles from the current one until the first idle cycle.
  task automatic wait_idle(output int n, output int en_first, output int en_last, input int base);
    n        = 0;
    en_first = -1;
    en_last  = -1;
    for (int k = 0; k < 100; k++) begin
      if (o_lcd_en) begin
        if (en_first < 0) en_first = base + k;
        en_last = base + k;
      end
      if (!o_status[0]) break;
      n++;
      tick(1'b0, 32'd0);
    end
  endtask

  task automatic run_txn(input string name, input logic [31:0] w, input int exp_busy);
    int n, ef, el;
    tick(1'b1, w);
    wait_idle(n, ef, el, 1);
    chk({name, " busy cycles"}, n, exp_busy);
    chk({name, " en first"}, ef, P_SETUP + 1);
    chk({name, " en last"}, el, P_SETUP + P_HIGH);
  endtask

  initial begin
    int n, ef, el;
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    chk("reset status", o_status, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Data write
    run_txn("data", 32'h8000_0241, 12);
    chk("data status", o_status, 32'h8000_0000);
    chk("data bus", {o_lcd_rs, o_lcd_data}, 9'h141);

    // Clear and function-set commands
    run_txn("clear", 32'h8000_0001, 16);
    chk("clear bus", {o_lcd_rs, o_lcd_data}, 9'h001);
    run_txn("funcset", 32'h8000_0038, 12);

    // Overrun then clear-on-accept
    tick(1'b1, 32'h0000_0041);
    repeat (3) tick(1'b0, 32'd0);
    tick(1'b1, 32'h0000_0042);
    chk("ovr data held", o_lcd_data, 8'h41);
    chk("ovr flag", o_status[1], 1'b1);
    wait_idle(n, ef, el, 0);
    run_txn("clr ovr", 32'h4000_0243, 12);
    chk("clr ovr status", o_status, 32'h0000_0000);
    chk("clr ovr data", o_lcd_data, 8'h43);

    // Back-to-back boundary: last WAIT cycle is dropped, first IDLE accepted
    tick(1'b1, 32'h8000_0038);
    repeat (11) tick(1'b0, 32'd0);
    tick(1'b1, 32'h8000_0039);
    chk("b2b drop status", o_status, 32'h8000_0002);
    chk("b2b drop data", o_lcd_data, 8'h38);
    run_txn("b2b accept", 32'h8000_0045, 12);
    chk("b2b accept data", o_lcd_data, 8'h45);

    // Reset mid-PULSE, with a write held during reset
    tick(1'b1, 32'h4000_0000);
    wait_idle(n, ef, el, 0);
    tick(1'b1, 32'h8000_0241);
    repeat (2) tick(1'b0, 32'd0);
    chk("pulse en", o_lcd_en, 1'b1);
    #2 rst_n = 1'b0;
    wr    = 1'b1;
    wdata = 32'h8000_0255;
    #1;
    chk("rst outputs", {o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_data}, 11'd0);
    chk("rst status", o_status, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wr = 1'b0;
    run_txn("after reset", 32'h8000_0241, 12);

    // ON toggle during WAIT
    tick(1'b1, 32'h8000_0038);
    repeat (8) tick(1'b0, 32'd0);
    tick(1'b1, 32'h0000_0000);
    chk("on toggle", {o_lcd_on, o_status[1]}, 2'b01);
    wait_idle(n, ef, el, 0);
    chk("on toggle busy", 9 + n, 12);

    // Randomized writes with occasional resets
    for (int i = 0; i < 500; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[7:0] = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      tick($urandom_range(0, 5) == 0, d);
    end
    repeat (30) tick(1'b0, 32'd0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
